clk_tick_scheduler: RTL and testbench

//  Central clock-enable scheduler: one fabric clock, N_CH independent tick (clock-enable) strobes.

---
 rtl/clk_tick_pkg.sv | 19 +
 rtl/tick_channel.sv | 81 ++++++++
 rtl/clk_tick_scheduler.sv | 100 ++++++++++
 tb/tb_clk_tick_scheduler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/clk_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_tick_pkg
// Brief    : Shared types and constants for the clock-enable tick scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package clk_tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Divide ratio loaded into every channel at reset (tick = CLK/2).
    localparam int DIV_RESET = 1;

endpackage
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// ============================================================================
// Module   : tick_channel
// Brief    : One tick channel: wrap counter, active/shadow divide ratio and a
//            registered one-cycle strobe. Pending port exists only when
//            TICK_OVERRUN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tick_channel
    import clk_tick_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    output logic             tick
`ifdef TICK_OVERRUN_EN
    ,
    output logic             pending
`endif
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == r_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= DIV_W'(DIV_RESET);
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= run_en && w_wrap;
            if (run_en) begin
                if (w_wrap) begin
                    // The strobe at this wrap used the old ratio; swap now.
                    r_cnt     <= '0;
                    if (r_pending) begin
                        r_div <= r_shadow;
                    end
                    r_pending <= we;
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                    if (we) begin
                        r_pending <= 1'b1;
                    end
                end
                if (we) begin
                    r_shadow <= wdata;
                end
            end else begin
                // Stopped or aligning: counter held at phase 0, ratios land directly.
                r_cnt     <= '0;
                r_pending <= 1'b0;
                if (we) begin
                    r_div <= wdata;
                end else if (r_pending) begin
                    r_div <= r_shadow;
                end
            end
        end
    end

    assign tick = r_tick;

`ifdef TICK_OVERRUN_EN
    assign pending = r_pending;
`endif

endmodule
`default_nettype wire

// File: rtl/clk_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : clk_tick_scheduler
// Brief    : N_CH programmable clock-enable strobes with run/align/stop FSM.
//            Optional cfg_overrun output when TICK_OVERRUN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module clk_tick_scheduler
    import clk_tick_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int DIV_W = 8,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             run,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [N_CH-1:0]  tick,
    output logic             busy
`ifdef TICK_OVERRUN_EN
    ,
    output logic             cfg_overrun
`endif
);

    state_t          r_state;
    state_t          w_state_next;
    logic            w_run_en;
    logic [N_CH-1:0] w_we;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (run) w_state_next = ALIGN;
            ALIGN:   w_state_next = run ? RUN : IDLE;
            RUN:     if (!run) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // Counting only while RUN is held; a sampled run=0 suppresses the strobe at once.
    assign w_run_en = (r_state == RUN) && run;

`ifdef TICK_OVERRUN_EN
    logic [N_CH-1:0] w_pending;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_we[i] = cfg_we && (int'(cfg_ch) == i);

        tick_channel #(
            .DIV_W (DIV_W)
        ) u_channel (
            .clk     (CLK),
            .rst     (RST),
            .run_en  (w_run_en),
            .we      (w_we[i]),
            .wdata   (cfg_div),
            .tick    (tick[i])
`ifdef TICK_OVERRUN_EN
            ,
            .pending (w_pending[i])
`endif
        );
    end

`ifdef TICK_OVERRUN_EN
    logic r_overrun;
    logic w_idle_entry;

    assign w_idle_entry = (r_state != IDLE) && (w_state_next == IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overrun <= 1'b0;
        end else if (w_idle_entry) begin
            r_overrun <= 1'b0;
        end else if (|(w_we & w_pending)) begin
            r_overrun <= 1'b1;
        end
    end

    assign cfg_overrun = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_tick_scheduler
// Brief    : Directed vector table plus hand sequences for clk_tick_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_tick_scheduler;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       run     = 1'b0;
    logic       cfg_we  = 1'b0;
    logic [1:0] cfg_ch  = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic [3:0] tick;
    logic       busy;
`ifdef TICK_OVERRUN_EN
    logic       cfg_overrun;
`endif

    always #5 clk = ~clk;

    clk_tick_scheduler #(
        .N_CH  (4),
        .DIV_W (8)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .run         (run),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .tick        (tick),
        .busy        (busy)
`ifdef TICK_OVERRUN_EN
        ,
        .cfg_overrun (cfg_overrun)
`endif
    );

    typedef struct {
        logic       run;
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic [3:0] tick;
        logic       busy;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic we, input logic [1:0] ch,
                       input logic [7:0] d, input logic [3:0] t, input logic b,
                       input logic o);
        vec_t v;
        v.run = r; v.we = we; v.ch = ch; v.div = d;
        v.tick = t; v.busy = b; v.ovr = o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs sampled there belong to the same cycle.
    task automatic drive(input logic r, input logic we, input logic [1:0] ch,
                         input logic [7:0] d);
        @(negedge clk);
        run = r; cfg_we = we; cfg_ch = ch; cfg_div = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset tick", tick, 4'h0);
        chk("reset busy", busy, 1'b0);
`ifdef TICK_OVERRUN_EN
        chk("reset overrun", cfg_overrun, 1'b0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        // Defaults, stop mid-period, restart re-phased.
        add(1,0,0,0, 4'h0,0,0); add(1,0,0,0, 4'h0,1,0); add(1,0,0,0, 4'h0,1,0);
        add(1,0,0,0, 4'h0,1,0); add(1,0,0,0, 4'hF,1,0); add(1,0,0,0, 4'h0,1,0);
        add(1,0,0,0, 4'hF,1,0); add(0,0,0,0, 4'h0,1,0); add(0,0,0,0, 4'h0,0,0);
        add(1,0,0,0, 4'h0,0,0); add(1,0,0,0, 4'h0,1,0); add(1,0,0,0, 4'h0,1,0);
        add(1,0,0,0, 4'h0,1,0); add(1,0,0,0, 4'hF,1,0); add(1,0,0,0, 4'h0,1,0);
        add(0,0,0,0, 4'hF,1,0); add(0,0,0,0, 4'h0,0,0);
        // IDLE writes ch0=0, ch1=3, then run.
        add(0,1,0,0, 4'h0,0,0); add(0,1,1,3, 4'h0,0,0);
        add(1,0,0,0, 4'h0,0,0); add(1,0,0,0, 4'h0,1,0); add(1,0,0,0, 4'h0,1,0);
        add(1,0,0,0, 4'h1,1,0); add(1,0,0,0, 4'hD,1,0); add(1,0,0,0, 4'h1,1,0);
        add(1,0,0,0, 4'hF,1,0); add(1,0,0,0, 4'h1,1,0); add(1,0,0,0, 4'hD,1,0);
        add(1,0,0,0, 4'h1,1,0);
        // k10: ch2 -> 4 mid-period; one more period of 2, then 5.
        add(1,1,2,4, 4'hF,1,0); add(1,0,0,0, 4'h1,1,0); add(1,0,0,0, 4'hD,1,0);
        add(1,0,0,0, 4'h1,1,0); add(1,0,0,0, 4'hB,1,0); add(1,0,0,0, 4'h1,1,0);
        add(1,0,0,0, 4'h9,1,0); add(1,0,0,0, 4'h5,1,0); add(1,0,0,0, 4'hB,1,0);
        add(1,0,0,0, 4'h1,1,0); add(1,0,0,0, 4'h9,1,0); add(1,0,0,0, 4'h1,1,0);
        add(1,0,0,0, 4'hF,1,0); add(1,0,0,0, 4'h1,1,0); add(1,0,0,0, 4'h9,1,0);
        // k25: ch1 -> 1 on its wrap cycle; takes effect at the following wrap.
        add(1,1,1,1, 4'h1,1,0); add(1,0,0,0, 4'hB,1,0); add(1,0,0,0, 4'h5,1,0);
        // k28/k29: two writes to ch2 before its wrap; last one (0) wins.
        add(1,1,2,2, 4'h9,1,0); add(1,1,2,0, 4'h1,1,0); add(1,0,0,0, 4'hB,1,1);
        add(1,0,0,0, 4'h1,1,1); add(1,0,0,0, 4'hF,1,1); add(1,0,0,0, 4'h5,1,1);
        add(1,0,0,0, 4'hF,1,1); add(0,0,0,0, 4'h5,1,1); add(0,0,0,0, 4'h0,0,0);

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].run, vecs[i].we, vecs[i].ch, vecs[i].div);
            chk($sformatf("vec%0d tick", i), tick, vecs[i].tick);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
`ifdef TICK_OVERRUN_EN
            chk($sformatf("vec%0d overrun", i), cfg_overrun, vecs[i].ovr);
`endif
        end

        // Reset mid-RUN with ch0 div=7 restores default ratios.
        drive(0, 1, 2'd0, 8'd7);
        chk("rst-seq idle busy", busy, 1'b0);
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            chk($sformatf("rst-seq k%0d tick0", k), tick[0], (k == 10));
            chk($sformatf("rst-seq k%0d busy", k), busy, (k >= 1));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst-seq after rst tick", tick, 4'h0);
        chk("rst-seq after rst busy", busy, 1'b0);
        rst = 1'b0; run = 1'b1;
        for (int k = 1; k < 8; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            chk($sformatf("rerun k%0d tick", k), tick, (k == 4 || k == 6) ? 4'hF : 4'h0);
            chk($sformatf("rerun k%0d busy", k), busy, 1'b1);
        end

        // Maximum ratio on ch3: period 256, first tick at cycle 258.
        drive(0, 0, 2'd0, 8'd0);
        drive(0, 1, 2'd3, 8'd255);
        for (int k = 0; k < 520; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            chk($sformatf("maxdiv k%0d tick3", k), tick[3], (k == 258 || k == 514));
        end
        drive(0, 0, 2'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
